// File: rtl/flags_intr_unit.sv
// -----------------------------------------------------------------------------
// flags_intr_unit
//
// Processor status flags (carry, zero, interrupt enable) with a one-deep
// shadow copy of C/Z, plus the single-source interrupt front end: a 2-flop
// synchronizer, a rising-edge detector, and a three-state request FSM that
// can remember one request that arrives while the previous one is in service.
//
// Ports
//   CLK          in   system clock, all state updates on the rising edge
//   RESET_N      in   asynchronous active-low reset
//   ALU_C/ALU_Z  in   carry / zero results from the ALU
//   FLG_C_SET    in   force C to 1
//   FLG_C_CLR    in   force C to 0 (wins over set and load)
//   FLG_C_LD     in   load C from the selected source
//   FLG_Z_LD     in   load Z from the selected source
//   FLG_LD_SEL   in   load source: 0 = ALU, 1 = shadow
//   FLG_SHAD_LD  in   copy current C/Z into the shadow registers
//   I_SET/I_CLR  in   interrupt-enable set / clear (clear wins)
//   INT_ACK      in   interrupt entry pulse from the control unit
//   INT_DONE     in   interrupt return pulse (RETID/RETIE)
//   INT_REQ      in   external interrupt request, asynchronous to CLK
//   C_FLAG       out  registered carry flag
//   Z_FLAG       out  registered zero flag
//   I_FLAG       out  registered interrupt-enable flag
//   INTR         out  interrupt request to the control unit (register-decoded)
// -----------------------------------------------------------------------------
module flags_intr_unit (
    input  logic CLK,
    input  logic RESET_N,
    input  logic ALU_C,
    input  logic ALU_Z,
    input  logic FLG_C_SET,
    input  logic FLG_C_CLR,
    input  logic FLG_C_LD,
    input  logic FLG_Z_LD,
    input  logic FLG_LD_SEL,
    input  logic FLG_SHAD_LD,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic INT_ACK,
    input  logic INT_DONE,
    input  logic INT_REQ,
    output logic C_FLAG,
    output logic Z_FLAG,
    output logic I_FLAG,
    output logic INTR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SERV = 2'd2
    } int_state_e;

    // Flag and shadow registers
    logic c_q, c_d;
    logic z_q, z_d;
    logic i_q, i_d;
    logic shad_c_q, shad_c_d;
    logic shad_z_q, shad_z_d;

    // Synchronizer / edge detector
    logic sync1_q, sync2_q, sync3_q;
    logic req_edge;

    // Interrupt FSM
    int_state_e state_q, state_d;
    logic       missed_q, missed_d;

    // -------------------------------------------------------------------------
    // Flag next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        c_d      = c_q;
        z_d      = z_q;
        i_d      = i_q;
        shad_c_d = shad_c_q;
        shad_z_d = shad_z_q;

        if (FLG_C_CLR) begin
            c_d = 1'b0;
        end else if (FLG_C_SET) begin
            c_d = 1'b1;
        end else if (FLG_C_LD) begin
            c_d = FLG_LD_SEL ? shad_c_q : ALU_C;
        end

        if (FLG_Z_LD) begin
            z_d = FLG_LD_SEL ? shad_z_q : ALU_Z;
        end

        // Shadow captures the pre-edge flags while restores read the pre-edge
        // shadow, so a simultaneous save and restore swaps the two.
        if (FLG_SHAD_LD) begin
            shad_c_d = c_q;
            shad_z_d = z_q;
        end

        // Entering an interrupt disables further interrupts.
        if (I_CLR || INT_ACK) begin
            i_d = 1'b0;
        end else if (I_SET) begin
            i_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Interrupt FSM next-state logic
    // -------------------------------------------------------------------------
    assign req_edge = sync2_q & ~sync3_q;

    always_comb begin
        state_d  = state_q;
        missed_d = missed_q;

        unique case (state_q)
            IDLE: begin
                if (req_edge) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                // An edge without INT_ACK merges with the pending request; an
                // edge together with INT_ACK is a new request to remember.
                if (INT_ACK) begin
                    state_d  = SERV;
                    missed_d = req_edge;
                end
            end
            SERV: begin
                if (req_edge) begin
                    missed_d = 1'b1;
                end
                if (INT_DONE) begin
                    state_d  = (missed_q || req_edge) ? PEND : IDLE;
                    missed_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                missed_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, which the shadow swap and the sync chain rely on.
    always_ff @(posedge CLK or negedge RESET_N) begin
        // NOTE: every register here is control state, so all of them are reset;
        // there is no storage array that could be left unreset.
        if (!RESET_N) begin
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            i_q      <= 1'b0;
            shad_c_q <= 1'b0;
            shad_z_q <= 1'b0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            state_q  <= IDLE;
            missed_q <= 1'b0;
        end else begin
            c_q      <= c_d;
            z_q      <= z_d;
            i_q      <= i_d;
            shad_c_q <= shad_c_d;
            shad_z_q <= shad_z_d;
            // Sync flops reset to 0, so a request held high through reset
            // release still yields exactly one edge.
            sync1_q  <= INT_REQ;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            state_q  <= state_d;
            missed_q <= missed_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from registers only
    // -------------------------------------------------------------------------
    assign C_FLAG = c_q;
    assign Z_FLAG = z_q;
    assign I_FLAG = i_q;
    assign INTR   = (state_q == PEND) & i_q;

endmodule
